// File: rtl/spi_reg_burst.sv
// spi_reg_burst: SPI slave register-access port.
// A command byte (bit 7 = write, low ADDR_W bits = start address) is followed
// by REG_W-bit data words, MSB first. All four SPI modes are selectable at
// run time through `mode`. The SPI pins are synchronised into the clk domain,
// and the SPI clock is recovered as edge pulses.
// Optional feature: define SPI_REG_BURST_AUTOINC_EN for multi-word bursts
// with address auto-increment. Without it, each frame carries one data word.
module spi_reg_burst #(
  parameter int ADDR_W = 7,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic              reg_rd_stb,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_dv,
  input  logic [7:0]        status,
  output logic              frame_err
);

  localparam int                CNT_W     = $clog2(REG_W);
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(REG_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  // [0],[1]: synchroniser flops; [2]: previous synchronised value for edges
  logic [2:0]        cs_q;
  logic [2:0]        sclk_q;
  logic [1:0]        mosi_q;

  state_t            state;
  logic [REG_W-1:0]  rx_sh;
  logic [REG_W-1:0]  tx_sh;
  logic [REG_W-1:0]  rx_next;
  logic [REG_W-1:0]  status_w;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  word_last;
  logic              skip_chg;      // swallow the first change edge (CPHA=1)
  logic              tx_load_pend;  // next change edge loads reg_data_i
  logic              addr_inc;      // bump reg_addr on the following cycle
  logic              word_done;     // single-word frame already complete

  logic              cs_fall;
  logic              cs_rise;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              sample_pulse;
  logic              change_pulse;
  logic              bit_active;
  logic              word_end;

  // Pin synchronisers; they hold along with everything else when ena is low
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // Chip select resets to "selected" so that a CS already low when reset
      // is released produces no falling edge: the FSM stays in IDLE until
      // the master really starts a new frame.
      cs_q   <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
    end else if (ena) begin
      cs_q   <= {cs_q[1:0], spi_cs_n};
      sclk_q <= {sclk_q[1:0], spi_clk};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  // SPI clock edges are gated by the pre-transition CS value, so a sample
  // edge that coincides with CS rising still completes its word.
  assign cs_fall   =  cs_q[2] & ~cs_q[1];
  assign cs_rise   = ~cs_q[2] &  cs_q[1];
  assign sclk_rise = ~cs_q[2] &  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~cs_q[2] & ~sclk_q[1] &  sclk_q[2];

  // Modes 0 and 3 sample on rising edges, modes 1 and 2 on falling edges
  assign sample_pulse = (mode[1] ^ mode[0]) ? sclk_fall : sclk_rise;
  assign change_pulse = (mode[1] ^ mode[0]) ? sclk_rise : sclk_fall;

  assign rx_next   = {rx_sh[REG_W-2:0], mosi_q[1]};
  assign status_w  = REG_W'(status) << (REG_W - 8);
  assign word_last = (state == CMD) ? CMD_LAST : WORD_LAST;

  assign bit_active = sample_pulse &&
                      ((state == CMD) ||
                       (((state == WR_DATA) || (state == RD_DATA)) && !word_done));
  assign word_end   = bit_active && (bit_cnt == word_last);
  assign cnt_next   = word_end   ? '0 :
                      bit_active ? bit_cnt + CNT_W'(1) : bit_cnt;

  assign spi_miso = tx_sh[REG_W-1];

  // Frame FSM, shift registers, bit counter and register-port strobes
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      rx_sh         <= '0;
      tx_sh         <= '0;
      bit_cnt       <= '0;
      reg_addr      <= '0;
      reg_data_o    <= '0;
      reg_data_o_dv <= 1'b0;
      reg_rd_stb    <= 1'b0;
      frame_err     <= 1'b0;
      skip_chg      <= 1'b0;
      tx_load_pend  <= 1'b0;
      addr_inc      <= 1'b0;
      word_done     <= 1'b0;
    end else if (ena) begin
      // NOTE: every state update here is non-blocking, so all tests in this
      // block see the values from before the edge and statement order only
      // matters where a later assignment deliberately overrides an earlier one.
      reg_data_o_dv <= 1'b0;
      reg_rd_stb    <= 1'b0;
      frame_err     <= 1'b0;
      addr_inc      <= 1'b0;

      if (addr_inc)
        reg_addr <= reg_addr + ADDR_W'(1);

      if (bit_active) begin
        rx_sh   <= rx_next;
        bit_cnt <= cnt_next;
      end

      // Transmit side: load a fresh read word after a word boundary,
      // otherwise shift left with zero fill
      if (change_pulse && (state != IDLE)) begin
        if (skip_chg) begin
          skip_chg <= 1'b0;
        end else if ((state == RD_DATA) && tx_load_pend) begin
          tx_sh        <= reg_data_i;
          tx_load_pend <= 1'b0;
          reg_rd_stb   <= 1'b1;
        end else begin
          tx_sh <= {tx_sh[REG_W-2:0], 1'b0};
        end
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state        <= CMD;
            bit_cnt      <= '0;
            tx_sh        <= status_w;
            skip_chg     <= mode[0];
            tx_load_pend <= 1'b0;
            word_done    <= 1'b0;
          end
        end
        CMD: begin
          if (word_end) begin
            reg_addr <= rx_next[ADDR_W-1:0];
            if (rx_next[7]) begin
              state <= WR_DATA;
            end else begin
              state        <= RD_DATA;
              tx_load_pend <= 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (word_end) begin
            reg_data_o    <= rx_next;
            reg_data_o_dv <= 1'b1;
`ifdef SPI_REG_BURST_AUTOINC_EN
            addr_inc      <= 1'b1;
`else
            word_done     <= 1'b1;
`endif
          end
        end
        RD_DATA: begin
          if (word_end) begin
`ifdef SPI_REG_BURST_AUTOINC_EN
            addr_inc     <= 1'b1;
            tx_load_pend <= 1'b1;
`else
            word_done    <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      // CS release ends the frame from any state; a partial word is an error
      if (cs_rise) begin
        state <= IDLE;
        if ((state != IDLE) && (cnt_next != '0))
          frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_burst.sv
// tb_spi_reg_burst: directed bench for spi_reg_burst.
// Two instances share the SPI clock/data lines with separate chip selects:
//   u_a: ADDR_W=3, REG_W=8  (writes, address wrap, mode 1/2 reads, errors, reset)
//   u_b: ADDR_W=7, REG_W=16 (mode 3 burst read)
// Expected values follow SPI_REG_BURST_AUTOINC_EN in the same way as the RTL.
module tb_spi_reg_burst;

`ifdef SPI_REG_BURST_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam int HALF = 8;  // SPI half period in clk cycles

  logic        clk = 1'b0;
  logic        rstb;
  logic        ena;
  logic [1:0]  mode;
  logic        cs_a;
  logic        cs_b;
  logic        spi_clk;
  logic        spi_mosi;
  logic [7:0]  status;

  logic        miso_a;
  logic        miso_b;
  logic [2:0]  addr_a;
  logic [6:0]  addr_b;
  logic [7:0]  rdata_a;
  logic [15:0] rdata_b;
  logic        stb_a;
  logic        stb_b;
  logic [7:0]  wdata_a;
  logic [15:0] wdata_b;
  logic        dv_a;
  logic        dv_b;
  logic        ferr_a;
  logic        ferr_b;

  int total = 0;
  int bad   = 0;

  int dv_cnt_a   = 0;
  int dv_cnt_b   = 0;
  int ferr_cnt_a = 0;
  int ferr_cnt_b = 0;
  int stb_cnt_a  = 0;
  int stb_cnt_b  = 0;
  logic [2:0] dv_addr_a [0:63];
  logic [7:0] dv_data_a [0:63];

  // Register files: A returns 0x50+addr, B returns addr*0x0101
  assign rdata_a = 8'h50 + {5'd0, addr_a};
  assign rdata_b = {1'b0, addr_b, 1'b0, addr_b};

  always #5 clk = ~clk;

  spi_reg_burst #(.ADDR_W(3), .REG_W(8)) u_a (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode),
    .spi_cs_n(cs_a), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(miso_a),
    .reg_addr(addr_a), .reg_data_i(rdata_a), .reg_rd_stb(stb_a),
    .reg_data_o(wdata_a), .reg_data_o_dv(dv_a), .status(status), .frame_err(ferr_a)
  );

  spi_reg_burst #(.ADDR_W(7), .REG_W(16)) u_b (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode),
    .spi_cs_n(cs_b), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(miso_b),
    .reg_addr(addr_b), .reg_data_i(rdata_b), .reg_rd_stb(stb_b),
    .reg_data_o(wdata_b), .reg_data_o_dv(dv_b), .status(status), .frame_err(ferr_b)
  );

  // Pulse monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (dv_a) begin
      dv_addr_a[dv_cnt_a] <= addr_a;
      dv_data_a[dv_cnt_a] <= wdata_a;
      dv_cnt_a            <= dv_cnt_a + 1;
    end
    if (dv_b)   dv_cnt_b   <= dv_cnt_b + 1;
    if (ferr_a) ferr_cnt_a <= ferr_cnt_a + 1;
    if (ferr_b) ferr_cnt_b <= ferr_cnt_b + 1;
    if (stb_a)  stb_cnt_a  <= stb_cnt_a + 1;
    if (stb_b)  stb_cnt_b  <= stb_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cs_assert(input bit sel);
    spi_clk = mode[1];
    repeat (HALF) @(negedge clk);
    if (sel) cs_b = 1'b0;
    else     cs_a = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_release(input bit sel);
    repeat (HALF) @(negedge clk);
    if (sel) cs_b = 1'b1;
    else     cs_a = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Master: shifts n bits of v (MSB first), captures MISO at each sample edge
  task automatic spi_bits(input bit sel, input int n, input logic [63:0] v,
                          output logic [63:0] m);
    m = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!mode[0]) begin
        spi_mosi = v[i];
        repeat (HALF) @(negedge clk);
        spi_clk = ~spi_clk;
        m = {m[62:0], (sel ? miso_b : miso_a)};
        repeat (HALF) @(negedge clk);
        spi_clk = ~spi_clk;
      end else begin
        spi_clk  = ~spi_clk;
        spi_mosi = v[i];
        repeat (HALF) @(negedge clk);
        spi_clk = ~spi_clk;
        m = {m[62:0], (sel ? miso_b : miso_a)};
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] m;
    int b_dv, b_ferr, b_stb;

    rstb = 1'b0; ena = 1'b1; mode = 2'd0;
    cs_a = 1'b1; cs_b = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    status = 8'h3C;
    repeat (4) @(negedge clk);

    // Reset values
    check("rst_miso",  64'(miso_a),  64'(0));
    check("rst_addr",  64'(addr_a),  64'(0));
    check("rst_wdata", 64'(wdata_a), 64'(0));
    check("rst_dv",    64'(dv_a),    64'(0));
    check("rst_stb",   64'(stb_a),   64'(0));
    check("rst_ferr",  64'(ferr_a),  64'(0));
    check("rst_wdata_b", 64'(wdata_b), 64'(0));
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0 single write: 0x85, 0xA5
    b_dv = dv_cnt_a; b_ferr = ferr_cnt_a;
    cs_assert(0); spi_bits(0, 16, 64'h85A5, m); cs_release(0);
    check("w1_miso",  m, 64'h3C00);
    check("w1_cnt",   64'(dv_cnt_a - b_dv), 64'(1));
    check("w1_addr",  64'(dv_addr_a[b_dv]), 64'(5));
    check("w1_data",  64'(dv_data_a[b_dv]), 64'hA5);
    check("w1_ferr",  64'(ferr_cnt_a - b_ferr), 64'(0));
    check("w1_addr_after", 64'(addr_a), 64'(AUTOINC ? 6 : 5));

    // Two data words: 0x82, 0x11, 0x22
    b_dv = dv_cnt_a; b_ferr = ferr_cnt_a;
    cs_assert(0); spi_bits(0, 24, 64'h821122, m); cs_release(0);
    check("w2_cnt",   64'(dv_cnt_a - b_dv), 64'(AUTOINC ? 2 : 1));
    check("w2_addr0", 64'(dv_addr_a[b_dv]), 64'(2));
    check("w2_data0", 64'(dv_data_a[b_dv]), 64'h11);
    check("w2_datal", 64'(dv_data_a[b_dv + (AUTOINC ? 1 : 0)]), 64'(AUTOINC ? 8'h22 : 8'h11));
    check("w2_ferr",  64'(ferr_cnt_a - b_ferr), 64'(0));
    check("w2_addr_after", 64'(addr_a), 64'(AUTOINC ? 4 : 2));

    // Wrap from address 7 (ADDR_W=3): 0x87, 0x01, 0x02, 0x03
    b_dv = dv_cnt_a;
    cs_assert(0); spi_bits(0, 32, 64'h87010203, m); cs_release(0);
    check("wrap_cnt",   64'(dv_cnt_a - b_dv), 64'(AUTOINC ? 3 : 1));
    check("wrap_addr0", 64'(dv_addr_a[b_dv]), 64'(7));
    check("wrap_addr1", 64'(dv_addr_a[b_dv + (AUTOINC ? 1 : 0)]), 64'(AUTOINC ? 0 : 7));
    check("wrap_addrl", 64'(dv_addr_a[b_dv + (AUTOINC ? 2 : 0)]), 64'(AUTOINC ? 1 : 7));
    check("wrap_datal", 64'(dv_data_a[b_dv + (AUTOINC ? 2 : 0)]), 64'(AUTOINC ? 3 : 1));

    // Mode 1 read from 4, status 0xC3
    status = 8'hC3; mode = 2'd1;
    b_stb = stb_cnt_a;
    cs_assert(0); spi_bits(0, 16, 64'h0400, m); cs_release(0);
    check("m1_miso", m, 64'hC354);
    check("m1_stb",  64'(stb_cnt_a - b_stb), 64'(1));
    check("m1_addr_after", 64'(addr_a), 64'(AUTOINC ? 5 : 4));

    // Mode 2 read from 6
    mode = 2'd2;
    b_stb = stb_cnt_a;
    cs_assert(0); spi_bits(0, 16, 64'h0600, m); cs_release(0);
    check("m2_miso", m, 64'hC356);
    check("m2_stb",  64'(stb_cnt_a - b_stb), 64'(AUTOINC ? 2 : 1));
    check("m2_addr_after", 64'(addr_a), 64'(AUTOINC ? 7 : 6));

    // Mode 3 burst read on the 16-bit instance: 0x02 plus 48 clocks
    mode = 2'd3;
    b_stb = stb_cnt_b; b_ferr = ferr_cnt_b; b_dv = dv_cnt_b;
    cs_assert(1); spi_bits(1, 56, 64'h0200000000000000 >> 8, m); cs_release(1);
    check("m3_miso", m, AUTOINC ? 64'h00C3_0202_0303_0404 : 64'h00C3_0202_0000_0000);
    check("m3_stb",  64'(stb_cnt_b - b_stb), 64'(AUTOINC ? 3 : 1));
    check("m3_addr_after", 64'(addr_b), 64'(AUTOINC ? 5 : 2));
    check("m3_ferr", 64'(ferr_cnt_b - b_ferr), 64'(0));
    check("m3_dv",   64'(dv_cnt_b - b_dv), 64'(0));

    // CS rise after 5 data bits
    mode = 2'd0;
    b_dv = dv_cnt_a; b_ferr = ferr_cnt_a;
    cs_assert(0); spi_bits(0, 13, 64'h1076, m); cs_release(0);
    check("perr_dv",   64'(dv_cnt_a - b_dv), 64'(0));
    check("perr_ferr", 64'(ferr_cnt_a - b_ferr), 64'(1));

    // CS rise after 5 command bits
    b_dv = dv_cnt_a; b_ferr = ferr_cnt_a;
    cs_assert(0); spi_bits(0, 5, 64'h15, m); cs_release(0);
    check("cerr_dv",   64'(dv_cnt_a - b_dv), 64'(0));
    check("cerr_ferr", 64'(ferr_cnt_a - b_ferr), 64'(1));

    // Next frame works normally: 0x81, 0x7E
    b_dv = dv_cnt_a; b_ferr = ferr_cnt_a;
    cs_assert(0); spi_bits(0, 16, 64'h817E, m); cs_release(0);
    check("rec_cnt",  64'(dv_cnt_a - b_dv), 64'(1));
    check("rec_addr", 64'(dv_addr_a[b_dv]), 64'(1));
    check("rec_data", 64'(dv_data_a[b_dv]), 64'h7E);
    check("rec_ferr", 64'(ferr_cnt_a - b_ferr), 64'(0));

    // Reset mid-frame: command 0x84 plus 4 data bits, then rstb low
    cs_assert(0); spi_bits(0, 12, 64'h84F, m);
    rstb = 1'b0;
    #1;
    check("mrst_addr",  64'(addr_a),  64'(0));
    check("mrst_wdata", 64'(wdata_a), 64'(0));
    check("mrst_miso",  64'(miso_a),  64'(0));
    check("mrst_dv",    64'(dv_a),    64'(0));
    check("mrst_ferr",  64'(ferr_a),  64'(0));
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (4) @(negedge clk);
    // Bits while CS is still low from before the reset are ignored
    b_dv = dv_cnt_a; b_ferr = ferr_cnt_a;
    spi_bits(0, 16, 64'h8355, m); cs_release(0);
    check("mrst_ign_dv",   64'(dv_cnt_a - b_dv), 64'(0));
    check("mrst_ign_ferr", 64'(ferr_cnt_a - b_ferr), 64'(0));
    check("mrst_ign_addr", 64'(addr_a), 64'(0));

    // Normal frame after reset: 0x86, 0x99
    b_dv = dv_cnt_a;
    cs_assert(0); spi_bits(0, 16, 64'h8699, m); cs_release(0);
    check("post_cnt",  64'(dv_cnt_a - b_dv), 64'(1));
    check("post_addr", 64'(dv_addr_a[b_dv]), 64'(6));
    check("post_data", 64'(dv_data_a[b_dv]), 64'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_burst.md
# spi_reg_burst

SPI slave register-access port, the parametrised successor of the single-byte SPI register interface. It carries a command byte followed by any number of REG_W-bit data words per chip-select frame, with address auto-increment. Reads and writes go through a simple register-file port. It sits between the chip pins and the design's register bank. All four SPI modes are supported, selected at run time.

## Interface
Parameters:
- `ADDR_W`, default 7: register address width; legal range 1..7.
- `REG_W`, default 8: data word width; must be 8, 16, 24 or 32.

Ports:
- `clk`  input  1  system clock. One clock domain; all logic is on the rising edge.
- `rstb`  input  1  reset, asynchronous, active-low.
- `ena`  input  1  clock enable. When low, every register holds, including the synchronisers.
- `mode`  input  2  SPI mode: CPOL = `mode[1]`, CPHA = `mode[0]`.
- `spi_cs_n`  input  1  chip select, active-low.
- `spi_clk`  input  1  SPI clock, asynchronous to `clk`.
- `spi_mosi`  input  1  serial data in.
- `spi_miso`  output  1  serial data out, MSB first.
- `reg_addr`  output  ADDR_W  current register address.
- `reg_data_i`  input  REG_W  read data. Combinational function of `reg_addr`.
- `reg_rd_stb`  output  1  one-cycle pulse when `reg_data_i` is captured for transmission.
- `reg_data_o`  output  REG_W  write data.
- `reg_data_o_dv`  output  1  one-cycle write strobe, qualifying `reg_data_o` and `reg_addr`.
- `status`  input  8  status byte, shifted out during the command byte.
- `frame_err`  output  1  one-cycle pulse when a frame ends mid-word.

## Operation
- **Input conditioning:** `spi_cs_n`, `spi_clk` and `spi_mosi` each pass through a 2-flop synchroniser. Edge pulses are derived from the synchronised values.
- **Edge gating:** `spi_clk` edges count only while synchronised `spi_cs_n` is 0.
- **Sample edge:**
  - Rising edge when `mode` is 0 or 3; falling edge when `mode` is 1 or 2.
  - The change edge is the opposite edge.
- **Frame format:**
  - Byte 0, bit 7: 1 = write, 0 = read.
  - Byte 0, bits [ADDR_W-1:0]: start address.
  - Other bits of byte 0: ignored.
  - Byte 0 is followed by data words of REG_W bits each, MSB first.
- **FSM states:** IDLE, CMD, WR_DATA, RD_DATA.
  - IDLE → CMD on CS falling edge.
  - CMD → WR_DATA or RD_DATA on the 8th sample edge.
  - WR_DATA and RD_DATA hold until CS rising edge, then go to IDLE.
  - CS rising edge from any state → IDLE.
- **Command capture:** on the 8th sample edge, `reg_addr` and the rw flag load from the RX shift register. `reg_addr` is valid the next cycle.
- **Write:**
  - At each REG_W-th sample edge in WR_DATA: `reg_data_o` ← RX shift register, `reg_data_o_dv` = 1 for one cycle.
  - `reg_addr` increments the cycle after the strobe.
- **Read, TX shift register:**
  - `status` loads on CS falling edge.
  - In RD_DATA, the first change edge after each word boundary loads `reg_data_i` instead of shifting, and pulses `reg_rd_stb`.
  - Every other change edge shifts left with zero fill.
  - In CPHA=1 modes, the first change edge of the frame is suppressed so that the `status` MSB is not lost.
- **Read, address:** `reg_addr` increments one cycle after the REG_W-th sample edge of each read word.
- **Write frames:** `spi_miso` shifts out `status`, then zeros.
- **Address wrap:** `reg_addr` wraps modulo 2^ADDR_W. From all ones it goes to 0.
- **Partial word at CS rise:** the partial word is discarded, with no strobe. `frame_err` pulses.
  - Applies in CMD when the bit count is 1..7.
  - Applies in data states when the bit count is 1..REG_W-1.
  - A CS rise on an exact word boundary is not an error.
- **Bit counter:** clears on CS falling and on each word boundary.

## Timing
- **Pin-to-pulse latency:** 3 clk cycles from a pin edge to its internal edge pulse.
- **SPI clock limit:** `spi_clk` high and low phases must each be at least 4 clk cycles.
- **Write strobe:** `reg_data_o_dv` asserts 1 cycle after the internal sample pulse of the last bit of the word.
- **Read data:** `reg_data_i` must be stable from 1 cycle after a `reg_addr` change until `reg_rd_stb`.
- **Reset values:**
  - `spi_miso` = 0, `reg_addr` = 0, `reg_data_o` = 0.
  - `reg_data_o_dv`, `reg_rd_stb`, `frame_err` = 0.
  - FSM = IDLE.
- **Reset mid-frame:**
  - Everything returns to the reset state immediately.
  - Bits arriving before the next CS falling edge are ignored, because the FSM stays in IDLE.
- **Simultaneous CS rise and word-completing sample edge:** the word completes and its strobe fires first, then IDLE. No `frame_err`.

## Configuration
- **`SPI_REG_BURST_AUTOINC_EN` defined:** burst behaviour as described above.
- **`SPI_REG_BURST_AUTOINC_EN` undefined:**
  - One data word per frame; `reg_addr` never increments.
  - After the first word the FSM ignores all further bits until CS rises.
  - No further strobes, and `spi_miso` shifts zeros.
  - A CS rise after the first word is not an error.

## Test plan
- **Mode 0 single write, REG_W=8:** frame 0x85, 0xA5 → one `reg_data_o_dv` with `reg_addr`=5 and `reg_data_o`=0xA5. `spi_miso` shows `status` during byte 0.
- **Mode 3 burst read, REG_W=16, `reg_data_i` = addr×0x0101:** frame 0x02 plus 48 clocks → MISO 0x0202, 0x0303, 0x0404; three `reg_rd_stb` pulses.
- **Wrap, ADDR_W=3:** write burst from address 7 with 3 words → strobes at addresses 7, 0, 1.
- **Mode 1 and mode 2 read, `status`=0xC3:** first 8 MISO bits = 0xC3; the CPHA=1 MSB is not lost.
- **CS rise after 5 data bits:** no write strobe, one `frame_err` pulse, FSM in IDLE. The next frame works normally.
- **Reset mid-frame, and feature-off build:** assert `rstb` mid-frame → outputs return to reset values. Without the macro, 2 words written → one strobe only.
